// File: rtl/pll_reset_seq.sv
// Reset sequencer on PLL c1: synchronizes/filters lock, then releases memory and CPU resets in stages.
// Optional loss counter built only when PLL_RSTSEQ_LOSSCNT_EN is defined.
module pll_reset_seq #(
  parameter int unsigned LOCK_FILT   = 16,
  parameter int unsigned HOLD_CYCLES = 64,
  parameter int unsigned STAGGER     = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       pll_locked,
  input  logic       sw_rst_n,
  output logic       rst_mem_n,
  output logic       rst_cpu_n,
  output logic       ready,
  output logic [2:0] state,
  output logic [7:0] loss_cnt
);

  typedef enum logic [2:0] {
    WAIT_LOCK = 3'd0,
    FILTER    = 3'd1,
    HOLD      = 3'd2,
    REL_MEM   = 3'd3,
    RUN       = 3'd4
  } state_t;

  localparam logic [15:0] FILT_LAST  = 16'(LOCK_FILT - 1);
  localparam logic [15:0] HOLD_LAST  = 16'(HOLD_CYCLES - 1);
  localparam logic [15:0] STAG_LAST  = 16'(STAGGER - 1);

  state_t      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic        s1_q, s2_q;
  logic        rst_mem_q, rst_cpu_q, ready_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
    end else begin
      s1_q <= pll_locked;
      s2_q <= s1_q;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = '0;
    case (state_q)
      WAIT_LOCK: begin
        if (s2_q) state_d = FILTER;
      end
      FILTER: begin
        if (!s2_q)                  state_d = WAIT_LOCK;
        else if (cnt_q == FILT_LAST) state_d = HOLD;
        else                         cnt_d   = cnt_q + 16'd1;
      end
      HOLD: begin
        if (!s2_q)                  state_d = WAIT_LOCK;
        else if (cnt_q == HOLD_LAST) state_d = REL_MEM;
        else                         cnt_d   = cnt_q + 16'd1;
      end
      REL_MEM: begin
        if (!s2_q)                  state_d = WAIT_LOCK;
        else if (cnt_q == STAG_LAST) state_d = RUN;
        else                         cnt_d   = cnt_q + 16'd1;
      end
      RUN: begin
        // lock loss wins over a simultaneous soft reset
        if (!s2_q)          state_d = WAIT_LOCK;
        else if (!sw_rst_n) state_d = HOLD;
      end
      default: state_d = WAIT_LOCK;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= WAIT_LOCK;
      cnt_q     <= '0;
      rst_mem_q <= 1'b0;
      rst_cpu_q <= 1'b0;
      ready_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rst_mem_q <= (state_d == REL_MEM) || (state_d == RUN);
      rst_cpu_q <= (state_d == RUN);
      ready_q   <= (state_d == RUN);
    end
  end

`ifdef PLL_RSTSEQ_LOSSCNT_EN
  logic [7:0] loss_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      loss_q <= '0;
    end else if ((state_q == RUN) && !s2_q && (loss_q != 8'hFF)) begin
      loss_q <= loss_q + 8'd1;
    end
  end

  assign loss_cnt = loss_q;
`else
  assign loss_cnt = 8'h00;
`endif

  assign rst_mem_n = rst_mem_q;
  assign rst_cpu_n = rst_cpu_q;
  assign ready     = ready_q;
  assign state     = state_q;

endmodule

// File: tb/tb_pll_reset_seq.sv
// Randomized bench for pll_reset_seq against a timeline model of the release sequence.
module tb_pll_reset_seq;

  localparam int unsigned LF = 16;
  localparam int unsigned HC = 64;
  localparam int unsigned SG = 8;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       pll_locked;
  logic       sw_rst_n;
  logic       rst_mem_n;
  logic       rst_cpu_n;
  logic       ready;
  logic [2:0] state;
  logic [7:0] loss_cnt;

  int unsigned tests  = 0;
  int unsigned errors = 0;

  // model: synchronizer taps, whether a sequence is in progress, and edges elapsed since FILTER entry
  bit          m_s1, m_s2, m_active;
  int unsigned m_t, m_loss;

  always #5 clk = ~clk;

  pll_reset_seq #(.LOCK_FILT(LF), .HOLD_CYCLES(HC), .STAGGER(SG)) dut (
    .clk(clk), .rst_n(rst_n), .pll_locked(pll_locked), .sw_rst_n(sw_rst_n),
    .rst_mem_n(rst_mem_n), .rst_cpu_n(rst_cpu_n), .ready(ready),
    .state(state), .loss_cnt(loss_cnt)
  );

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic int unsigned phase();
    if (!m_active)           return 0;
    if (m_t < LF)            return 1;
    if (m_t < LF + HC)       return 2;
    if (m_t < LF + HC + SG)  return 3;
    return 4;
  endfunction

  function automatic int unsigned exp_loss();
`ifdef PLL_RSTSEQ_LOSSCNT_EN
    return m_loss;
`else
    return 0;
`endif
  endfunction

  task automatic model_reset();
    m_s1 = 0; m_s2 = 0; m_active = 0; m_t = 0; m_loss = 0;
  endtask

  task automatic compare_all();
    int unsigned ph;
    ph = phase();
    check_eq("state", state, ph);
    check_eq("rst_mem_n", rst_mem_n, ph >= 3);
    check_eq("rst_cpu_n", rst_cpu_n, ph == 4);
    check_eq("ready", ready, ph == 4);
    check_eq("loss_cnt", loss_cnt, exp_loss());
  endtask

  task automatic step();
    int unsigned ph;
    @(posedge clk);
    if (!rst_n) begin
      model_reset();
    end else begin
      ph = phase();
      if (!m_active) begin
        if (m_s2) begin m_active = 1; m_t = 0; end
      end else if (!m_s2) begin
        if (ph == 4 && m_loss < 255) m_loss++;
        m_active = 0;
      end else if (ph == 4) begin
        if (!sw_rst_n) m_t = LF;
      end else begin
        m_t++;
      end
      m_s2 = m_s1;
      m_s1 = pll_locked;
    end
    #1;
    compare_all();
  endtask

  task automatic run_until(input int unsigned target, input int unsigned budget, input string tag);
    for (int unsigned i = 0; i < budget && phase() != target; i++) step();
    check_eq(tag, state, target);
  endtask

  initial begin
    int unsigned mem_e, cpu_e, drop_left;
    model_reset();
    rst_n = 1'b0; pll_locked = 1'b1; sw_rst_n = 1'b1;
    #1;
    check_eq("reset_state", state, 0);
    check_eq("reset_mem", rst_mem_n, 0);
    check_eq("reset_cpu", rst_cpu_n, 0);
    check_eq("reset_ready", ready, 0);
    check_eq("reset_loss", loss_cnt, 0);

    // lock already present while in reset
    for (int i = 0; i < 5; i++) step();
    rst_n = 1'b1;
    mem_e = 0; cpu_e = 0;
    for (int unsigned e = 1; e <= 150 && cpu_e == 0; e++) begin
      step();
      if (mem_e == 0 && rst_mem_n) mem_e = e;
      if (cpu_e == 0 && rst_cpu_n) cpu_e = e;
    end
    check_eq("acq_mem_edge", mem_e, 3 + LF + HC);
    check_eq("acq_cpu_edge", cpu_e, 3 + LF + HC + SG);

    // soft reset pulse
    for (int i = 0; i < 3; i++) step();
    sw_rst_n = 1'b0;
    step();
    sw_rst_n = 1'b1;
    check_eq("sw_state", state, 2);
    check_eq("sw_mem_low", rst_mem_n, 0);
    mem_e = 0; cpu_e = 0;
    for (int unsigned e = 1; e <= 150 && cpu_e == 0; e++) begin
      step();
      if (mem_e == 0 && rst_mem_n) mem_e = e;
      if (cpu_e == 0 && rst_cpu_n) cpu_e = e;
    end
    check_eq("sw_mem_edge", mem_e, HC);
    check_eq("sw_cpu_edge", cpu_e, HC + SG);
    check_eq("sw_loss", loss_cnt, 0);

    // lock loss and soft reset reach the FSM on the same edge
    pll_locked = 1'b0;
    step();
    step();
    sw_rst_n = 1'b0;
    step();
    sw_rst_n = 1'b1;
    pll_locked = 1'b1;
    check_eq("simul_state", state, 0);
    check_eq("simul_loss", loss_cnt, exp_loss());

    // one-cycle glitch in FILTER at cnt=10
    for (int unsigned i = 0; i < 100 && !(m_active && m_t == 10); i++) step();
    check_eq("glitch_pre", state, 1);
    pll_locked = 1'b0;
    step();
    pll_locked = 1'b1;
    mem_e = 0;
    for (int unsigned e = 1; e <= 150 && mem_e == 0; e++) begin
      step();
      if (mem_e == 0 && rst_mem_n) mem_e = e;
    end
    check_eq("glitch_mem_edge", mem_e, 3 + LF + HC);

    // random lock drops and soft resets
    drop_left = 0;
    for (int i = 0; i < 3000; i++) begin
      if (drop_left > 0) begin
        pll_locked = 1'b0;
        drop_left--;
      end else if ($urandom_range(0, 99) == 0) begin
        pll_locked = 1'b0;
        drop_left = $urandom_range(0, 4);
      end else begin
        pll_locked = 1'b1;
      end
      sw_rst_n = ($urandom_range(0, 39) != 0);
      step();
    end
    pll_locked = 1'b1; sw_rst_n = 1'b1;

    // repeated losses from RUN drive the counter into saturation
    for (int i = 0; i < 300; i++) begin
      run_until(4, 200, "loss_reach_run");
      pll_locked = 1'b0;
      drop_left = $urandom_range(1, 4);
      for (int unsigned k = 0; k < drop_left; k++) step();
      pll_locked = 1'b1;
    end
    step(); step();
`ifdef PLL_RSTSEQ_LOSSCNT_EN
    check_eq("loss_sat", loss_cnt, 255);
`else
    check_eq("loss_sat", loss_cnt, 0);
`endif

    // async reset between edges while in REL_MEM
    run_until(3, 200, "reach_rel_mem");
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("async_mem", rst_mem_n, 0);
    check_eq("async_state", state, 0);
    check_eq("async_loss", loss_cnt, 0);
    model_reset();
    step();
    rst_n = 1'b1;
    run_until(4, 200, "post_async_run");

    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule
